// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting N requesters bounded write tenures on one shared W-bit register.
// The winner search starts at the rotating pointer, so the previous owner ends up with the lowest priority.
module shared_reg_arbiter #(
  parameter int unsigned W        = 8,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [(1 << ID_W)-1:0]       req,
  input  logic [(1 << ID_W)-1:0]       wen,
  input  logic [(1 << ID_W)*W-1:0]     wdata,
  output logic [(1 << ID_W)-1:0]       gnt,
  output logic [ID_W-1:0]              owner,
  output logic                         busy,
  output logic [W-1:0]                 q,
  output logic                         timeout
);

  localparam int unsigned N    = 1 << ID_W;
  localparam int unsigned HC_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [HC_W-1:0] hold_cnt;
  logic [ID_W-1:0] win_c;
  logic [W-1:0]    lane_c;
  logic            last_c;

  // First requester at or after ptr; the index wraps naturally because N is a power of two.
  always_comb begin
    logic found;
    win_c = ptr;
    found = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && req[ptr + ID_W'(k)]) begin
        win_c = ptr + ID_W'(k);
        found = 1'b1;
      end
    end
  end

  assign lane_c = wdata[int'(owner)*int'(W) +: W];
  assign last_c = (hold_cnt == HC_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      q        <= '0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            owner    <= win_c;
            gnt      <= N'(1) << win_c;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + HC_W'(1);
          if (wen[owner]) begin
            q <= lane_c;
          end
          // A voluntary release takes precedence, so timeout only flags a still-requesting owner.
          if (!req[owner] || last_c) begin
            state   <= RELEASE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= req[owner];
            ptr     <= owner + ID_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed stimulus queues expected tenures, writes and
// reset snapshots; a negedge monitor pops and compares them as the DUT produces the events.
module tb_shared_reg_arbiter;

  localparam int unsigned W    = 8;
  localparam int unsigned ID_W = 2;
  localparam int unsigned N    = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   wen;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [ID_W-1:0] owner;
  logic           busy;
  logic [W-1:0]   q;
  logic           timeout;

  shared_reg_arbiter #(.W(W), .ID_W(ID_W), .HOLD_MAX(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wen(wen), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] owner;
    int              len;   // 0: length not checked
    int              gap;   // 0: gap not checked
    logic            to;
  } tenure_t;

  typedef struct {
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] owner;
    logic            busy;
    logic [W-1:0]    q;
    logic            to;
  } snap_t;

  tenure_t     gq[$];
  logic [W-1:0] qq[$];
  snap_t       sq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tenure_t mk_t(input logic [N-1:0] g, input int o, input int len, input int gap, input logic to);
    tenure_t t;
    t.gnt = g; t.owner = ID_W'(o); t.len = len; t.gap = gap; t.to = to;
    return t;
  endfunction

  task automatic push_reset_snap();
    snap_t s;
    s.gnt = '0; s.owner = '0; s.busy = 1'b0; s.q = '0; s.to = 1'b0;
    sq.push_back(s);
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  // Monitor
  logic [W-1:0] prev_q = '0;
  logic         prev_busy = 1'b0;
  tenure_t      cur;
  int           run = 0;
  int           idle_cnt = 0;

  always @(negedge clk) begin
    if (!reset && sq.size() > 0) begin
      snap_t s;
      s = sq.pop_front();
      check(gnt === s.gnt, "reset_gnt", 32'(gnt), 32'(s.gnt));
      check(owner === s.owner, "reset_owner", 32'(owner), 32'(s.owner));
      check(busy === s.busy, "reset_busy", 32'(busy), 32'(s.busy));
      check(q === s.q, "reset_q", 32'(q), 32'(s.q));
      check(timeout === s.to, "reset_timeout", 32'(timeout), 32'(s.to));
    end
    if (q !== prev_q) begin
      if (qq.size() == 0) begin
        check(1'b0, "q_unexpected_change", 32'(q), 32'(prev_q));
      end else begin
        logic [W-1:0] e;
        e = qq.pop_front();
        check(q === e, "q_value", 32'(q), 32'(e));
      end
    end
    prev_q = q;

    if (busy && !prev_busy) begin
      if (gq.size() == 0) begin
        check(1'b0, "unexpected_grant", 32'(gnt), 32'h0);
        cur = mk_t(gnt, int'(owner), 0, 0, 1'b0);
      end else begin
        cur = gq.pop_front();
        check(gnt === cur.gnt, "grant_gnt", 32'(gnt), 32'(cur.gnt));
        check(owner === cur.owner, "grant_owner", 32'(owner), 32'(cur.owner));
        if (cur.gap != 0) check(idle_cnt == cur.gap, "grant_gap", 32'(idle_cnt), 32'(cur.gap));
      end
      run = 1;
    end else if (busy) begin
      run++;
      check(gnt === cur.gnt, "tenure_gnt_stable", 32'(gnt), 32'(cur.gnt));
    end

    if (!busy && prev_busy) begin
      if (cur.len != 0) check(run == cur.len, "tenure_len", 32'(run), 32'(cur.len));
      check(timeout === cur.to, "release_timeout", 32'(timeout), 32'(cur.to));
      check(gnt === '0, "release_gnt", 32'(gnt), 32'h0);
      idle_cnt = 1;
    end else if (!busy) begin
      idle_cnt++;
      if (timeout) check(1'b0, "spurious_timeout", 32'(timeout), 32'h0);
    end
    prev_busy = busy;
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    wen   = '0;
    wdata = '0;

    // 1: reset with random inputs, then idle
    push_reset_snap();
    push_reset_snap();
    repeat (3) begin
      req   = N'($urandom);
      wen   = N'($urandom);
      wdata = (N*W)'($urandom);
      @(posedge clk); #1;
    end
    req = '0; wen = '0; wdata = '0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 2: single requester writes 0xA5, then drops req
    gq.push_back(mk_t(4'b0010, 1, 2, 0, 1'b0));
    qq.push_back(8'hA5);
    req = 4'b0010; wen = 4'b0010; set_lane(1, 8'hA5);
    repeat (2) @(posedge clk);
    #1;
    req = '0; wen = '0; wdata = '0;
    repeat (4) @(posedge clk);
    #1;

    // Reset pulse to restart the pointer at 0
    qq.push_back(8'h00);
    push_reset_snap();
    reset = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;

    // 3: all requesting -> 0,1,2,3,0 with forced 8-cycle tenures
    gq.push_back(mk_t(4'b0001, 0, 8, 0, 1'b1));
    gq.push_back(mk_t(4'b0010, 1, 8, 2, 1'b1));
    gq.push_back(mk_t(4'b0100, 2, 8, 2, 1'b1));
    gq.push_back(mk_t(4'b1000, 3, 8, 2, 1'b1));
    gq.push_back(mk_t(4'b0001, 0, 8, 2, 1'b1));
    req = 4'b1111;
    repeat (49) @(posedge clk);
    #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;

    // 4: owner 2; other lanes writing are ignored, then lane 2 writes 0x3C
    gq.push_back(mk_t(4'b0100, 2, 3, 0, 1'b0));
    qq.push_back(8'h3C);
    req = 4'b0100;
    @(posedge clk); #1;
    wen = 4'b1011;
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h77); set_lane(3, 8'h44);
    @(posedge clk); #1;
    wen = 4'b0100; set_lane(2, 8'h3C);
    @(posedge clk); #1;
    req = '0; wen = '0; wdata = '0;
    repeat (4) @(posedge clk);
    #1;

    // 5: owner 0 with req[3] rising mid-tenure; next grant goes to 3
    gq.push_back(mk_t(4'b0001, 0, 3, 0, 1'b0));
    gq.push_back(mk_t(4'b1000, 3, 2, 2, 1'b0));
    req = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    req = 4'b1001;
    @(posedge clk); #1;
    req = 4'b1000;
    repeat (4) @(posedge clk);
    #1;
    req = '0;
    repeat (4) @(posedge clk);
    #1;

    // 6: reset mid-tenure after 0x5A write; next search restarts from 0
    gq.push_back(mk_t(4'b0100, 2, 0, 0, 1'b0));
    qq.push_back(8'h5A);
    qq.push_back(8'h00);
    gq.push_back(mk_t(4'b0010, 1, 8, 0, 1'b1));
    req = 4'b0100; wen = 4'b0100; set_lane(2, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    wen = '0;
    @(posedge clk); #2;
    push_reset_snap();
    reset = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    req = 4'b1110; wdata = '0;
    repeat (9) @(posedge clk);
    #1;
    req = '0;
    repeat (5) @(posedge clk);
    #1;

    check(gq.size() == 0, "grants_outstanding", 32'(gq.size()), 32'h0);
    check(qq.size() == 0, "writes_outstanding", 32'(qq.size()), 32'h0);
    check(sq.size() == 0, "snapshots_outstanding", 32'(sq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
